// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - phase encodings and PC width shared by every datapath stage
package multicycle_sequencer_pkg;

  localparam int PC_W = 8;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    IDLE   = 3'd7
  } state_e;

endpackage

// File: rtl/multicycle_sequencer_perf_counter.sv
// rtl/multicycle_sequencer_perf_counter.sv - 16-bit saturating event counter with enable
module perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - phase FSM and PC owner for the multi-cycle datapath
// Optional SEQ_PERF_COUNT_EN adds cycle_count / retired_count outputs.
module multicycle_sequencer #(
  parameter int MAX_PC = 11,
  parameter int PC_W   = multicycle_sequencer_pkg::PC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            imem_ack,
  input  logic            dmem_ack,
  input  logic            is_mem,
  input  logic            wb_en,
  input  logic            invalid_instr,
  input  logic            halt_instr,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [2:0]      state,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            rf_we,
  output logic            done
`ifdef SEQ_PERF_COUNT_EN
  ,
  output logic [15:0]     cycle_count,
  output logic [15:0]     retired_count
`endif
);

  import multicycle_sequencer_pkg::*;

  localparam logic [PC_W:0] MAX_PC_X = (PC_W + 1)'(MAX_PC);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            wb_en_q, wb_en_d;
  logic            taken_q, taken_d;
  logic            done_q, done_d;
  logic            retire;
  logic            take;
  logic [PC_W-1:0] take_tgt;
  logic [PC_W-1:0] next_pc;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    wb_en_d  = wb_en_q;
    taken_d  = taken_q;
    done_d   = 1'b0;
    retire   = 1'b0;
    // An invalid instruction retires straight out of EXEC, before the capture lands.
    take     = (state_q == EXEC) ? branch_taken  : taken_q;
    take_tgt = (state_q == EXEC) ? branch_target : tgt_q;
    next_pc  = take ? take_tgt : pc_q + PC_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH:  if (imem_ack) state_d = DECODE;
      DECODE: state_d = READ;
      READ:   state_d = EXEC;
      EXEC: begin
        wb_en_d = wb_en;
        taken_d = branch_taken;
        tgt_d   = branch_target;
        if (invalid_instr) begin
          retire = 1'b1;
        end else if (halt_instr) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else if (is_mem) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM:     if (dmem_ack) state_d = WB;
      WB:      retire = 1'b1;
      default: state_d = state_q;
    endcase

    if (retire) begin
      if ({1'b0, next_pc} > MAX_PC_X) begin
        state_d = HALT;
        done_d  = 1'b1;
      end else begin
        pc_d    = next_pc;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      tgt_q   <= '0;
      wb_en_q <= 1'b0;
      taken_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      wb_en_q <= wb_en_d;
      taken_q <= taken_d;
      done_q  <= done_d;
    end
  end

  assign state    = state_q;
  assign pc       = pc_q;
  assign imem_req = (state_q == FETCH);
  assign dmem_req = (state_q == MEM);
  assign rf_we    = (state_q == WB) && wb_en_q;
  assign done     = done_q;

`ifdef SEQ_PERF_COUNT_EN
  logic cyc_en, ret_en;

  assign cyc_en = (state_q != IDLE) && (state_q != HALT);
  assign ret_en = retire || ((state_q == EXEC) && !invalid_instr && halt_instr);

  perf_counter u_cycle_count (
    .clk   (clk),
    .reset (reset),
    .en    (cyc_en),
    .count (cycle_count)
  );

  perf_counter u_retired_count (
    .clk   (clk),
    .reset (reset),
    .en    (ret_en),
    .count (retired_count)
  );
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - trace-model bench for multicycle_sequencer (SEQ_PERF_COUNT_EN aware)
module tb_multicycle_sequencer;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_READ = 2, ST_EXEC = 3;
  localparam int ST_MEM = 4, ST_WB = 5, ST_HALT = 6, ST_IDLE = 7;
  localparam int MAXPC = 11;

  typedef struct {
    bit       rst, start, iack, dack, ism, wbe, inv, hlt, tk;
    bit [7:0] tgt;
    bit       chk;
    int       st, pc;
    bit       ireq, dreq, we, dn;
    int       cc, rc;
  } cyc_t;

  typedef struct {
    int iw, dw;
    bit inv, hlt, mem, wb, tk;
    int tgt;
    bit rst_mem;
  } ins_t;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic       imem_ack = 1'b0, dmem_ack = 1'b0, is_mem = 1'b0, wb_en = 1'b0;
  logic       invalid_instr = 1'b0, halt_instr = 1'b0, branch_taken = 1'b0;
  logic [7:0] branch_target = 8'd0;
  logic [2:0] state;
  logic [7:0] pc;
  logic       imem_req, dmem_req, rf_we, done;
`ifdef SEQ_PERF_COUNT_EN
  logic [15:0] cycle_count, retired_count;
`endif

  multicycle_sequencer #(.MAX_PC(MAXPC), .PC_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_ack      (imem_ack),
    .dmem_ack      (dmem_ack),
    .is_mem        (is_mem),
    .wb_en         (wb_en),
    .invalid_instr (invalid_instr),
    .halt_instr    (halt_instr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .state         (state),
    .pc            (pc),
    .imem_req      (imem_req),
    .dmem_req      (dmem_req),
    .rf_we         (rf_we),
    .done          (done)
`ifdef SEQ_PERF_COUNT_EN
    ,
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
`endif
  );

  always #5 clk = ~clk;

  cyc_t trace[$];
  ins_t prog[$];
  cyc_t cur;
  int   cur_idx;
  bit   chk_en = 1'b0;
  int   total = 0, bad = 0;
  int   we_cnt, dm_cnt, done_cnt, done_idx, done_pc, ks;
  int   done_cc, done_rc, late_cc, late_rc;

  task automatic cmp(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s (trace cycle %0d): got %0d expected %0d", nm, cur_idx, act, exp);
    end
  endtask

  function automatic cyc_t mk(int st, int p, int cc, int rc);
    cyc_t r;
    r.rst   = 1'b0;
    r.start = (st == ST_HALT) ? 1'($urandom_range(0, 1)) : 1'b0;
    r.iack  = 1'($urandom_range(0, 1));
    r.dack  = 1'($urandom_range(0, 1));
    r.ism   = 1'($urandom_range(0, 1));
    r.wbe   = 1'($urandom_range(0, 1));
    r.inv   = 1'($urandom_range(0, 1));
    r.hlt   = 1'($urandom_range(0, 1));
    r.tk    = 1'($urandom_range(0, 1));
    r.tgt   = 8'($urandom_range(0, 255));
    r.chk   = 1'b1;
    r.st    = st;
    r.pc    = p;
    r.ireq  = (st == ST_FETCH);
    r.dreq  = (st == ST_MEM);
    r.we    = 1'b0;
    r.dn    = 1'b0;
    r.cc    = cc;
    r.rc    = rc;
    return r;
  endfunction

  function automatic ins_t alu();
    ins_t d;
    d.iw = 0; d.dw = 0; d.inv = 0; d.hlt = 0; d.mem = 0;
    d.wb = 1; d.tk = 0; d.tgt = 0; d.rst_mem = 0;
    return d;
  endfunction

  task automatic halt_tail(int p, int cc, int rc);
    cyc_t r;
    r = mk(ST_HALT, p, cc, rc);
    r.dn = 1'b1;
    trace.push_back(r);
    for (int i = 0; i < 11; i++) trace.push_back(mk(ST_HALT, p, cc, rc));
  endtask

  // Expand the instruction list into the per-cycle trace the sequencer must produce.
  task automatic build();
    cyc_t r;
    ins_t d;
    int   n = 0, p = 0, cc = 0, rc = 0, np;
    trace.delete();
    r = mk(ST_IDLE, 0, 0, 0); r.rst = 1'b1; r.chk = 1'b0; trace.push_back(r);
    trace.push_back(mk(ST_IDLE, 0, 0, 0));
    r = mk(ST_IDLE, 0, 0, 0); r.start = 1'b1; trace.push_back(r);
    ks = trace.size() - 1;
    forever begin
      d = (n < prog.size()) ? prog[n] : alu();
      n++;
      if (n > 30) begin d.hlt = 1; d.inv = 0; end
      for (int j = 0; j <= d.iw; j++) begin
        r = mk(ST_FETCH, p, cc, rc); r.iack = (j == d.iw); trace.push_back(r); cc++;
      end
      trace.push_back(mk(ST_DECODE, p, cc, rc)); cc++;
      trace.push_back(mk(ST_READ, p, cc, rc)); cc++;
      r = mk(ST_EXEC, p, cc, rc);
      r.inv = d.inv; r.hlt = d.hlt; r.ism = d.mem; r.wbe = d.wb; r.tk = d.tk; r.tgt = 8'(d.tgt);
      trace.push_back(r); cc++;
      if (!d.inv) begin
        if (d.hlt) begin
          rc++;
          halt_tail(p, cc, rc);
          return;
        end
        if (d.mem) begin
          for (int j = 0; j <= d.dw; j++) begin
            r = mk(ST_MEM, p, cc, rc); r.dack = (j == d.dw);
            if (d.rst_mem && j == 0) begin
              r.rst = 1'b1;
              trace.push_back(r);
              for (int k = 0; k < 3; k++) trace.push_back(mk(ST_IDLE, 0, 0, 0));
              return;
            end
            trace.push_back(r); cc++;
          end
        end
        r = mk(ST_WB, p, cc, rc); r.we = d.wb; trace.push_back(r); cc++;
      end
      rc++;
      np = d.tk ? d.tgt : (p + 1) % 256;
      if (np > MAXPC) begin
        halt_tail(p, cc, rc);
        return;
      end
      p = np;
    end
  endtask

  task automatic run();
    we_cnt = 0; dm_cnt = 0; done_cnt = 0; done_idx = -100; done_pc = -1;
    done_cc = -1; done_rc = -1; late_cc = -1; late_rc = -1;
    for (int k = 0; k < trace.size(); k++) begin
      reset         = trace[k].rst;
      start         = trace[k].start;
      imem_ack      = trace[k].iack;
      dmem_ack      = trace[k].dack;
      is_mem        = trace[k].ism;
      wb_en         = trace[k].wbe;
      invalid_instr = trace[k].inv;
      halt_instr    = trace[k].hlt;
      branch_taken  = trace[k].tk;
      branch_target = trace[k].tgt;
      cur           = trace[k];
      cur_idx       = k;
      chk_en        = 1'b1;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cur.chk) begin
        cmp("state", int'(state), cur.st);
        cmp("pc", int'(pc), cur.pc);
        cmp("imem_req", int'(imem_req), int'(cur.ireq));
        cmp("dmem_req", int'(dmem_req), int'(cur.dreq));
        cmp("rf_we", int'(rf_we), int'(cur.we));
        cmp("done", int'(done), int'(cur.dn));
`ifdef SEQ_PERF_COUNT_EN
        cmp("cycle_count", int'(cycle_count), cur.cc);
        cmp("retired_count", int'(retired_count), cur.rc);
`endif
      end
      if (rf_we) we_cnt++;
      if (dmem_req) dm_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = cur_idx;
        done_pc  = int'(pc);
`ifdef SEQ_PERF_COUNT_EN
        done_cc = int'(cycle_count);
        done_rc = int'(retired_count);
`endif
      end
`ifdef SEQ_PERF_COUNT_EN
      if (cur_idx == done_idx + 10) begin
        late_cc = int'(cycle_count);
        late_rc = int'(retired_count);
      end
`endif
    end
  end

  initial begin
    ins_t d;
    reset = 1'b1;
    @(posedge clk);
    #1;

    prog.delete();
    build(); run();
    cmp("s1_done_pulses", done_cnt, 1);
    cmp("s1_start_to_done", done_idx - ks - 1, 60);
    cmp("s1_final_pc", done_pc, 11);
    cmp("s1_rf_we_pulses", we_cnt, 12);
`ifdef SEQ_PERF_COUNT_EN
    cmp("s1_cycle_count", done_cc, 60);
    cmp("s1_retired_count", done_rc, 12);
    cmp("s1_cycle_count_later", late_cc, 60);
    cmp("s1_retired_count_later", late_rc, 12);
`endif

    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back(alu());
    d = alu(); d.mem = 1; d.dw = 3; prog.push_back(d);
    build(); run();
    cmp("s2_dmem_req_cycles", dm_cnt, 4);

    prog.delete();
    for (int i = 0; i < 2; i++) prog.push_back(alu());
    d = alu(); d.tk = 1; d.tgt = 8; prog.push_back(d);
    build(); run();
    cmp("s3_branch_rf_we", we_cnt, 7);
    cmp("s3_branch_final_pc", done_pc, 11);

    prog.delete();
    for (int i = 0; i < 2; i++) prog.push_back(alu());
    d = alu(); d.tk = 1; d.tgt = 20; prog.push_back(d);
    build(); run();
    cmp("s3_far_branch_done", done_cnt, 1);
    cmp("s3_far_branch_pc", done_pc, 2);

    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(alu());
    d = alu(); d.inv = 1; prog.push_back(d);
    build(); run();
    cmp("s4_invalid_rf_we", we_cnt, 11);
    cmp("s4_invalid_dmem", dm_cnt, 0);

    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back(alu());
    d = alu(); d.mem = 1; d.dw = 2; d.rst_mem = 1; prog.push_back(d);
    build(); run();
    cmp("s5_reset_no_done", done_cnt, 0);

    for (int r = 0; r < 8; r++) begin
      prog.delete();
      for (int i = 0; i < 25; i++) begin
        d       = alu();
        d.iw    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        d.dw    = int'($urandom_range(0, 3));
        d.inv   = ($urandom_range(0, 9) == 0);
        d.hlt   = ($urandom_range(0, 19) == 0);
        d.mem   = ($urandom_range(0, 2) == 0);
        d.wb    = 1'($urandom_range(0, 1));
        d.tk    = ($urandom_range(0, 3) == 0);
        d.tgt   = int'($urandom_range(0, 13));
        prog.push_back(d);
      end
      build(); run();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
